// File: rtl/draw_rect.sv
// Rectangle rasteriser: walks a clipped rectangle in row-major order and issues
// one datapath write instruction per drawn pixel (solid, outline or checker fill).
module draw_rect #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 32
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      rx,
  input  logic [Y_W-1:0]      ry,
  input  logic [X_W-1:0]      rw,
  input  logic [Y_W-1:0]      rh,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [1:0]          mode,
  output logic                finished,
  output logic [15:0]         pix_count,
  input  logic                finished_dp,
  input  logic [RESULT_W-1:0] result_dp,
  output logic                start_dp,
  output logic [INSTR_W-1:0]  instruction_dp
);

  localparam int XE = X_W + 1;
  localparam int YE = Y_W + 1;

  typedef enum logic [2:0] {IDLE, EVAL, DISPATCH, DELAY, WAIT} state_t;

  state_t              state_q;
  logic [X_W-1:0]      rx_q, rw_q;
  logic [Y_W-1:0]      ry_q, rh_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [1:0]          mode_q;
  logic [XE-1:0]       cx_q, cx_d;
  logic [YE-1:0]       cy_q, cy_d;
  logic                finished_q;
  logic                startDp_q;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [15:0]         pixCount_q, pixCount_d;

  logic [XE-1:0] rxE, lastX;
  logic [YE-1:0] ryE, lastY, endY;
  logic          onScreen, modeHit, drawPix, lastPix;
  logic          unusedResult;

  assign unusedResult = ^result_dp;

  // Cursor maths is one bit wider than the coordinates so rx+rw never wraps.
  always_comb begin
    rxE      = {1'b0, rx_q};
    ryE      = {1'b0, ry_q};
    lastX    = rxE + {1'b0, rw_q} - XE'(1);
    lastY    = ryE + {1'b0, rh_q} - YE'(1);
    endY     = ryE + {1'b0, rh_q};
    onScreen = (cx_q < XE'(SCREEN_W)) && (cy_q < YE'(SCREEN_H));
    case (mode_q)
      2'b01:   modeHit = (cx_q == rxE) || (cx_q == lastX) || (cy_q == ryE) || (cy_q == lastY);
      2'b10:   modeHit = ~(cx_q[0] ^ rx_q[0] ^ cy_q[0] ^ ry_q[0]);
      default: modeHit = 1'b1;
    endcase
    drawPix = onScreen && modeHit;
    if (cx_q == lastX) begin
      cx_d = rxE;
      cy_d = cy_q + YE'(1);
    end else begin
      cx_d = cx_q + XE'(1);
      cy_d = cy_q;
    end
    lastPix    = (cy_d == endY);
    pixCount_d = (pixCount_q == 16'hFFFF) ? pixCount_q : pixCount_q + 16'd1;
    instr_d                                 = '0;
    instr_d[X_W-1:0]                        = cx_q[X_W-1:0];
    instr_d[X_W +: Y_W]                     = cy_q[Y_W-1:0];
    instr_d[X_W+Y_W +: COLOUR_W]            = colour_q;
    instr_d[X_W+Y_W+COLOUR_W]               = 1'b1;
    instr_d[INSTR_W-1 -: 4]                 = 4'd1;
  end

  // start_dp rises on entry to DISPATCH and falls on entry to WAIT, giving a two-cycle request.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      finished_q <= 1'b1;
      startDp_q  <= 1'b0;
      instr_q    <= '0;
      pixCount_q <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rw_q       <= '0;
      rh_q       <= '0;
      colour_q   <= '0;
      mode_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rx_q       <= rx;
            ry_q       <= ry;
            rw_q       <= rw;
            rh_q       <= rh;
            colour_q   <= colour;
            mode_q     <= mode;
            cx_q       <= {1'b0, rx};
            cy_q       <= {1'b0, ry};
            pixCount_q <= '0;
            finished_q <= 1'b0;
            state_q    <= ((rw == '0) || (rh == '0)) ? IDLE : EVAL;
          end else begin
            finished_q <= 1'b1;
          end
        end
        EVAL: begin
          if (drawPix) begin
            startDp_q <= 1'b1;
            instr_q   <= instr_d;
            state_q   <= DISPATCH;
          end else if (lastPix) begin
            finished_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
          end
        end
        DISPATCH: state_q <= DELAY;
        DELAY: begin
          startDp_q <= 1'b0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (finished_dp) begin
            pixCount_q <= pixCount_d;
            if (lastPix) begin
              finished_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              cx_q    <= cx_d;
              cy_q    <= cy_d;
              state_q <= EVAL;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign finished       = finished_q;
  assign pix_count      = pixCount_q;
  assign start_dp       = startDp_q;
  assign instruction_dp = instr_q;

endmodule

// File: tb/tb_draw_rect.sv
// Scoreboard bench for draw_rect: directed rectangles push expected instructions,
// a monitor checks each dispatch, and a responder models the datapath handshake.
module tb_draw_rect;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  rx, rw;
  logic [6:0]  ry, rh;
  logic [2:0]  colour;
  logic [1:0]  mode;
  logic        finished;
  logic [15:0] pix_count;
  logic        finished_dp;
  logic [31:0] result_dp;
  logic        start_dp;
  logic [31:0] instruction_dp;

  int          assertCount = 0;
  int          failCount = 0;
  int          dispatchCount = 0;
  int          dpDelay = 0;
  int          strayReq = 0;
  logic [31:0] sb[$];

  draw_rect dut (
    .clock(clock), .resetn(resetn), .start(start), .rx(rx), .ry(ry), .rw(rw), .rh(rh),
    .colour(colour), .mode(mode), .finished(finished), .pix_count(pix_count),
    .finished_dp(finished_dp), .result_dp(result_dp), .start_dp(start_dp),
    .instruction_dp(instruction_dp)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushPix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    sb.push_back({4'd1, 9'd0, 1'b1, c, y, x});
  endtask

  task automatic applyStimulus(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] aw,
                               input logic [6:0] ah, input logic [2:0] ac, input logic [1:0] am,
                               input bit disturb);
    rx = ax; ry = ay; rw = aw; rh = ah; colour = ac; mode = am;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (disturb) begin
      rx = 8'd50; ry = 7'd50; rw = 8'd1; rh = 7'd1; colour = 3'd0; mode = 2'b01;
    end
  endtask

  task automatic waitFinished(input bit disturb, output int cycles);
    cycles = 0;
    while (!finished && cycles < 500) begin
      cycles++;
      start = disturb && (cycles == 3);
      @(negedge clock);
    end
    start = 1'b0;
    checkOutput("job finished", finished, 1);
  endtask

  // Datapath model: answers finished_dp dpDelay cycles after start_dp falls.
  initial begin : responder
    bit rspPrev = 0;
    bit active = 0;
    int cnt = 0;
    int strayDone = 0;
    finished_dp = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      finished_dp = 1'b0;
      if (!resetn) active = 0;
      else if (rspPrev && !start_dp) begin
        active = 1;
        cnt = dpDelay;
      end
      if (strayReq != strayDone) begin
        finished_dp = 1'b1;
        strayDone = strayReq;
      end else if (active) begin
        if (cnt == 0) begin
          finished_dp = 1'b1;
          active = 0;
        end else cnt--;
      end
      rspPrev = start_dp;
    end
  end

  initial begin : monitor
    bit prevStart = 0;
    int highLen = 0;
    bit waitActive = 0;
    logic [31:0] lastExp = '0;
    logic [31:0] expInstr;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prevStart = 0; highLen = 0; waitActive = 0; lastExp = '0;
      end else begin
        if (start_dp && !prevStart) begin
          dispatchCount++;
          waitActive = 0;
          if (sb.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected dispatch: got %0h, expected none", instruction_dp);
          end else begin
            expInstr = sb.pop_front();
            checkOutput("dispatch instr", instruction_dp, expInstr);
            lastExp = expInstr;
          end
        end else if (waitActive) begin
          checkOutput("instr stable in WAIT", instruction_dp, lastExp);
        end
        if (start_dp) highLen++;
        else if (prevStart) begin
          checkOutput("start_dp width", highLen, 2);
          highLen = 0;
          waitActive = 1;
        end
        if (finished_dp) waitActive = 0;
        prevStart = start_dp;
      end
    end
  end

  initial begin : stimulus
    int cycles;
    int base;
    resetn = 1'b0; start = 1'b0; rx = '0; ry = '0; rw = '0; rh = '0;
    colour = '0; mode = '0; result_dp = 32'hDEAD_BEEF;
    repeat (3) @(negedge clock);
    checkOutput("reset finished", finished, 1);
    checkOutput("reset start_dp", start_dp, 0);
    checkOutput("reset instr", instruction_dp, 0);
    checkOutput("reset pix_count", pix_count, 0);
    resetn = 1'b1;
    @(negedge clock);

    $display("[TB] solid 3x2 with mid-job start");
    dpDelay = 1;
    sb.push_back(32'h1005_0302);
    pushPix(3, 3, 3'b010); pushPix(4, 3, 3'b010);
    pushPix(2, 4, 3'b010); pushPix(3, 4, 3'b010); pushPix(4, 4, 3'b010);
    applyStimulus(8'd2, 7'd3, 8'd3, 7'd2, 3'b010, 2'b00, 1'b1);
    waitFinished(1'b1, cycles);
    checkOutput("solid cycles", cycles, 30);
    checkOutput("solid pix_count", pix_count, 6);
    checkOutput("solid queue empty", sb.size(), 0);

    $display("[TB] outline 4x3");
    dpDelay = 0;
    pushPix(0, 0, 3'd5); pushPix(1, 0, 3'd5); pushPix(2, 0, 3'd5); pushPix(3, 0, 3'd5);
    pushPix(0, 1, 3'd5); pushPix(3, 1, 3'd5);
    pushPix(0, 2, 3'd5); pushPix(1, 2, 3'd5); pushPix(2, 2, 3'd5); pushPix(3, 2, 3'd5);
    applyStimulus(8'd0, 7'd0, 8'd4, 7'd3, 3'd5, 2'b01, 1'b0);
    waitFinished(1'b0, cycles);
    checkOutput("outline cycles", cycles, 42);
    checkOutput("outline pix_count", pix_count, 10);
    checkOutput("outline queue empty", sb.size(), 0);

    $display("[TB] clipped corner, mode 11");
    pushPix(158, 118, 3'd7); pushPix(159, 118, 3'd7);
    pushPix(158, 119, 3'd7); pushPix(159, 119, 3'd7);
    applyStimulus(8'd158, 7'd118, 8'd4, 7'd4, 3'd7, 2'b11, 1'b0);
    waitFinished(1'b0, cycles);
    checkOutput("clip cycles", cycles, 28);
    checkOutput("clip pix_count", pix_count, 4);
    checkOutput("clip queue empty", sb.size(), 0);

    $display("[TB] degenerate rectangles");
    base = dispatchCount;
    applyStimulus(8'd5, 7'd5, 8'd0, 7'd2, 3'd1, 2'b00, 1'b0);
    waitFinished(1'b0, cycles);
    checkOutput("rw0 low cycles", cycles, 1);
    checkOutput("rw0 pix_count", pix_count, 0);
    applyStimulus(8'd5, 7'd5, 8'd2, 7'd0, 3'd1, 2'b00, 1'b0);
    waitFinished(1'b0, cycles);
    checkOutput("rh0 low cycles", cycles, 1);
    checkOutput("degenerate dispatches", dispatchCount, base);

    $display("[TB] checker 2x2 with slow datapath");
    dpDelay = 5;
    pushPix(0, 0, 3'd6); pushPix(1, 1, 3'd6);
    applyStimulus(8'd0, 7'd0, 8'd2, 7'd2, 3'd6, 2'b10, 1'b0);
    waitFinished(1'b0, cycles);
    checkOutput("checker cycles", cycles, 20);
    checkOutput("checker pix_count", pix_count, 2);
    checkOutput("checker queue empty", sb.size(), 0);

    $display("[TB] reset during WAIT of pixel 2");
    dpDelay = 3;
    base = dispatchCount;
    pushPix(10, 10, 3'd1); pushPix(11, 10, 3'd1);
    applyStimulus(8'd10, 7'd10, 8'd3, 7'd1, 3'd1, 2'b00, 1'b0);
    cycles = 0;
    while (!(dispatchCount == base + 2 && !start_dp) && cycles < 100) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("pixel2 dispatched", dispatchCount, base + 2);
    checkOutput("pix_count before reset", pix_count, 1);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("midjob reset finished", finished, 1);
    checkOutput("midjob reset start_dp", start_dp, 0);
    checkOutput("midjob reset instr", instruction_dp, 0);
    checkOutput("midjob reset pix_count", pix_count, 0);
    @(negedge clock);
    resetn = 1'b1;
    strayReq++;
    repeat (8) @(negedge clock);
    checkOutput("post-reset finished", finished, 1);
    checkOutput("post-reset pix_count", pix_count, 0);
    checkOutput("post-reset dispatches", dispatchCount, base + 2);
    checkOutput("reset queue empty", sb.size(), 0);

    $display("[TB] single pixel after reset");
    dpDelay = 0;
    pushPix(0, 0, 3'd4);
    applyStimulus(8'd0, 7'd0, 8'd1, 7'd1, 3'd4, 2'b00, 1'b0);
    waitFinished(1'b0, cycles);
    checkOutput("single cycles", cycles, 4);
    checkOutput("single pix_count", pix_count, 1);
    checkOutput("single queue empty", sb.size(), 0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/draw_rect.md
DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 Parameter SCREEN_W, default 160: screen width in pixels.
REQ-002 Parameter SCREEN_H, default 120: screen height in pixels.
REQ-003 Parameter X_W, default 8: x coordinate width.
REQ-004 Parameter Y_W, default 7: y coordinate width.
REQ-005 Parameter COLOUR_W, default 3: colour width.
REQ-006 Parameter INSTR_W, default 32: datapath instruction width; SHALL be at least 5+COLOUR_W+Y_W+X_W.
REQ-007 Parameter RESULT_W, default 32: datapath result width.
REQ-008 Ports SHALL be:
- clock  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request a rectangle; sampled only in IDLE.
- rx  in  X_W  rectangle left edge.
- ry  in  Y_W  rectangle top edge.
- rw  in  X_W  rectangle width.
- rh  in  Y_W  rectangle height.
- colour  in  COLOUR_W  fill colour.
- mode  in  2  00 solid, 01 outline, 10 checker, 11 treated as solid.
- finished  out  1  high when idle.
- pix_count  out  16  pixels dispatched by the last or current job.
- finished_dp  in  1  datapath result valid.
- result_dp  in  RESULT_W  datapath result; ignored.
- start_dp  out  1  datapath request.
- instruction_dp  out  INSTR_W  datapath instruction.

Function
REQ-009 States SHALL be IDLE, EVAL, DISPATCH, DELAY, WAIT.
REQ-010 IDLE with start=1 SHALL latch rx, ry, rw, rh, colour, mode, set cx=rx, cy=ry, clear pix_count, drive finished=0 from the next cycle, and go to IDLE if rw==0 or rh==0, else EVAL.
REQ-011 start SHALL be ignored outside IDLE; latched inputs SHALL NOT change mid-job.
REQ-012 EVAL SHALL spend one cycle deciding whether pixel (cx,cy) is drawn.
REQ-013 A pixel is drawn iff cx<SCREEN_W, cy<SCREEN_H, and the mode condition holds.
REQ-014 Solid: always. Outline: cx==rx, cx==rx+rw-1, cy==ry, or cy==ry+rh-1. Checker: bit 0 of (cx-rx)+(cy-ry) is 0.
REQ-015 Comparisons SHALL use widths one bit wider than X_W/Y_W so that rx+rw and ry+rh never wrap; off-screen pixels are clipped, not wrapped.
REQ-016 EVAL with a drawn pixel SHALL go to DISPATCH; otherwise it SHALL advance the cursor and stay in EVAL, or finish.
REQ-017 DISPATCH SHALL assert start_dp=1 and load instruction_dp = {4'd1, zero pad, 1'b1, colour, cy, cx}, x in the LSBs; go to DELAY.
REQ-018 DELAY SHALL hold start_dp=1; go to WAIT.
REQ-019 WAIT SHALL drive start_dp=0 and hold instruction_dp unchanged until finished_dp=1.
REQ-020 On finished_dp=1 in WAIT, the block SHALL increment pix_count (saturating at 16'hFFFF), advance the cursor, and go to EVAL or finish.
REQ-021 finished_dp SHALL be ignored in every state except WAIT.
REQ-022 Cursor advance: if cx==rx+rw-1, then cx=rx and cy=cy+1; otherwise cx=cx+1.
REQ-023 The job is last when the advanced cy==ry+rh; finishing SHALL set finished=1 and state IDLE in the same cycle.
REQ-024 Pixel order SHALL be row-major, left to right, top to bottom; there is exactly one datapath transaction per drawn pixel.
REQ-025 Minimum drawn-pixel period SHALL be 4 cycles (EVAL, DISPATCH, DELAY, WAIT with immediate finished_dp); each skipped pixel costs 1 cycle.

Reset
REQ-026 When resetn=0 at a clock edge, the block SHALL force: state=IDLE, finished=1, start_dp=0, instruction_dp=0, pix_count=0, cursor and latched inputs 0.
REQ-027 Reset mid-job SHALL abandon the job immediately, with no further start_dp; a finished_dp arriving after reset SHALL be ignored.

Verification
REQ-028 Solid, rx=2 ry=3 rw=3 rh=2 colour=3'b010, finished_dp one cycle after start_dp falls -> 6 instructions, (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), each {4'd1,9'd0,1,3'b010,y,x}; pix_count=6; finished=1.
REQ-029 Outline, rx=0 ry=0 rw=4 rh=3 -> 10 pixels, (1,1) and (2,1) skipped; pix_count=10.
REQ-030 Clip, solid, rx=158 ry=118 rw=4 rh=4 -> only (158,118)(159,118)(158,119)(159,119) dispatched; pix_count=4.
REQ-031 rw=0 with start -> finished low for exactly 1 cycle, start_dp never asserted, pix_count=0.
REQ-032 Checker, rx=0 ry=0 rw=2 rh=2, finished_dp delayed 5 cycles -> instructions for (0,0) and (1,1) only; start_dp high for exactly 2 cycles per pixel; instruction_dp stable throughout WAIT.
REQ-033 resetn low during WAIT of pixel 2 -> all outputs at reset values the next cycle; a later finished_dp does not change state or pix_count.
